// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit counters; PCF lookup -> predicted_valid_IF/predicted_PC_IF, EX resolve (PC_EX, BranchIsE, BranchE, BranchTarget) -> update and predicted_EX_error
module branch_target_buffer #(
  parameter int ENTRIES = 64
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        StallE,
  input  logic        FlushE,
  input  logic [31:0] PC_EX,
  input  logic        BranchIsE,
  input  logic        BranchE,
  input  logic [31:0] BranchTarget,
  output logic        predicted_valid_IF,
  output logic [31:0] predicted_PC_IF,
  output logic        predicted_EX_error
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  logic [ENTRIES-1:0]      valid;
  logic [ENTRIES-1:0][1:0] ctr;
  logic [TAG_W-1:0]        tag_q [ENTRIES];
  logic [31:0]             tgt_q [ENTRIES];
  logic                    pd_taken, pe_taken;
  logic [31:0]             pd_tgt, pe_tgt;
  logic [IDX_W-1:0]        fi, ui;
  logic [TAG_W-1:0]        ft, ut;
  logic                    f_hit, u_hit, upd, unused;
  logic [1:0]              uc;
  assign unused = ^{PCF[1:0], PC_EX[1:0]};
  assign fi = PCF[IDX_W+1:2];
  assign ft = PCF[31:IDX_W+2];
  assign ui = PC_EX[IDX_W+1:2];
  assign ut = PC_EX[31:IDX_W+2];
  assign f_hit = valid[fi] && tag_q[fi] == ft;
  assign u_hit = valid[ui] && tag_q[ui] == ut;
  assign upd = BranchIsE && !StallE;
  assign uc = ctr[ui];
  assign predicted_valid_IF = f_hit && ctr[fi][1];
  assign predicted_PC_IF = f_hit ? tgt_q[fi] : '0;
  // gated by rst_n so a branch sitting in EX during reset never raises a redirect
  assign predicted_EX_error = rst_n && BranchIsE &&
    ((pe_taken != BranchE) || (pe_taken && BranchE && pe_tgt != BranchTarget));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      ctr      <= '0;
      pd_taken <= 1'b0;
      pd_tgt   <= '0;
      pe_taken <= 1'b0;
      pe_tgt   <= '0;
    end else begin
      pd_taken <= FlushD ? 1'b0 : StallD ? pd_taken : predicted_valid_IF;
      pd_tgt   <= FlushD ? '0   : StallD ? pd_tgt   : predicted_PC_IF;
      pe_taken <= FlushE ? 1'b0 : StallE ? pe_taken : pd_taken;
      pe_tgt   <= FlushE ? '0   : StallE ? pe_tgt   : pd_tgt;
      if (upd && u_hit)
        ctr[ui] <= BranchE ? uc + {1'b0, uc != 2'd3} : uc - {1'b0, uc != 2'd0};
      else if (upd && BranchE) begin
        valid[ui] <= 1'b1;
        ctr[ui]   <= 2'd2;
      end
    end
  end
  // a taken update either refreshes a hit (same tag) or allocates a miss
  always_ff @(posedge clk) begin
    if (upd && BranchE) begin
      tag_q[ui] <= ut;
      tgt_q[ui] <= BranchTarget;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed scenarios plus random traffic checked against a map-based BTB model
module tb_branch_target_buffer;
  localparam int ENTRIES = 64;
  localparam int IDX_W = $clog2(ENTRIES);
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] PCF = '0, PC_EX = '0, BranchTarget = '0;
  logic        StallD = 0, FlushD = 0, StallE = 0, FlushE = 0, BranchIsE = 0, BranchE = 0;
  logic        predicted_valid_IF, predicted_EX_error;
  logic [31:0] predicted_PC_IF;
  int n_cmp = 0, n_err = 0;
  int unsigned m_pc [int];
  int unsigned m_tgt [int];
  int          m_ctr [int];
  bit          pd_t, pe_t;
  int unsigned pd_g, pe_g;
  logic        obs_pv, obs_err;
  logic [31:0] obs_ppc;
  int unsigned pool [6] = '{32'h100, 32'h104, 32'h100 + 4 * ENTRIES, 32'h300, 32'h504, 32'h1100};
  int unsigned tpool [4] = '{32'h80, 32'h200, 32'h700, 32'h600};

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .StallD(StallD), .FlushD(FlushD),
    .StallE(StallE), .FlushE(FlushE), .PC_EX(PC_EX), .BranchIsE(BranchIsE),
    .BranchE(BranchE), .BranchTarget(BranchTarget),
    .predicted_valid_IF(predicted_valid_IF), .predicted_PC_IF(predicted_PC_IF),
    .predicted_EX_error(predicted_EX_error));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input int unsigned pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_hit(input int unsigned pc);
    int i = idx_of(pc);
    return m_pc.exists(i) && (m_pc[i] >> (IDX_W + 2)) == (pc >> (IDX_W + 2));
  endfunction

  function automatic void m_reset();
    m_pc.delete(); m_tgt.delete(); m_ctr.delete();
    pd_t = 0; pd_g = 0; pe_t = 0; pe_g = 0;
  endfunction

  function automatic void m_update(input int unsigned pc, input bit be, input int unsigned bt);
    int i = idx_of(pc);
    if (m_hit(pc)) begin
      if (be) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = bt;
      end else
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
    end else if (be) begin
      m_pc[i] = pc; m_tgt[i] = bt; m_ctr[i] = 2;
    end
  endfunction

  task automatic step(input int unsigned pcf, input bit sd, fd, se, fe,
                      input int unsigned pcex, input bit bie, be, input int unsigned bt);
    bit ev, ee;
    int unsigned et;
    PCF = pcf; StallD = sd; FlushD = fd; StallE = se; FlushE = fe;
    PC_EX = pcex; BranchIsE = bie; BranchE = be; BranchTarget = bt;
    #1;
    ev = m_hit(pcf) && m_ctr[idx_of(pcf)] >= 2;
    et = m_hit(pcf) ? m_tgt[idx_of(pcf)] : 0;
    ee = bie && ((pe_t != be) || (pe_t && be && pe_g != bt));
    obs_pv = predicted_valid_IF; obs_ppc = predicted_PC_IF; obs_err = predicted_EX_error;
    check("pred_valid", {31'b0, obs_pv}, {31'b0, ev});
    check("pred_pc", obs_ppc, et);
    check("ex_error", {31'b0, obs_err}, {31'b0, ee});
    @(posedge clk);
    if (fe) begin pe_t = 0; pe_g = 0; end else if (!se) begin pe_t = pd_t; pe_g = pd_g; end
    if (fd) begin pd_t = 0; pd_g = 0; end else if (!sd) begin pd_t = ev; pd_g = et; end
    if (bie && !se) m_update(pcex, be, bt);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned pcf);
    step(pcf, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    #1;
    check("rst_pv", {31'b0, predicted_valid_IF}, 0);
    check("rst_pc", predicted_PC_IF, 0);
    check("rst_err", {31'b0, predicted_EX_error}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // cold miss
    step(32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 32'h80);
    check("cold_err", {31'b0, obs_err}, 1);
    idle(32'h100);
    check("cold_pv", {31'b0, obs_pv}, 1);
    check("cold_pc", obs_ppc, 32'h80);
    // hysteresis T,T,N,N,N
    step(32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 32'h80); check("hys_pv0", {31'b0, obs_pv}, 1);
    step(32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 32'h80); check("hys_pv1", {31'b0, obs_pv}, 1);
    step(32'h100, 0, 0, 0, 0, 32'h100, 1, 0, 32'h80); check("hys_pv2", {31'b0, obs_pv}, 1);
    step(32'h100, 0, 0, 0, 0, 32'h100, 1, 0, 32'h80); check("hys_pv3", {31'b0, obs_pv}, 1);
    step(32'h100, 0, 0, 0, 0, 32'h100, 1, 0, 32'h80); check("hys_pv4", {31'b0, obs_pv}, 0);
    idle(32'h100); check("hys_pv5", {31'b0, obs_pv}, 0);
    // retrain to ctr=3, then target change
    for (int k = 0; k < 3; k++) step(32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 32'h80);
    idle(32'h100);
    idle(32'h100);
    step(32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 32'h200);
    check("tchg_err", {31'b0, obs_err}, 1);
    idle(32'h100);
    check("tchg_pc", obs_ppc, 32'h200);
    // alias
    idle(32'h100 + 4 * ENTRIES);
    check("alias_pv", {31'b0, obs_pv}, 0);
    check("alias_pc", obs_ppc, 0);
    // flush of a predicted-taken instruction entering EX
    idle(32'h100);
    step(32'h300, 0, 0, 0, 1, 0, 0, 0, 0);
    step(32'h300, 0, 0, 0, 0, 32'h400, 1, 0, 0);
    check("flush_err", {31'b0, obs_err}, 0);
    idle(32'h100);
    check("flush_pc", obs_ppc, 32'h200);
    // stall: one update only after release
    for (int k = 0; k < 3; k++) step(32'h504, 0, 0, 1, 0, 32'h504, 1, 1, 32'h600);
    step(32'h504, 0, 0, 0, 0, 32'h504, 1, 1, 32'h600);
    idle(32'h504);
    check("stall_pv", {31'b0, obs_pv}, 1);
    check("stall_pc", obs_ppc, 32'h600);
    step(32'h504, 0, 0, 0, 0, 32'h504, 1, 0, 32'h600);
    idle(32'h504);
    check("stall_once", {31'b0, obs_pv}, 0);
    // same-cycle lookup and update
    step(32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 32'h700);
    check("same_old", obs_ppc, 32'h200);
    idle(32'h100);
    check("same_new", obs_ppc, 32'h700);
    // async reset mid-run
    PCF = 32'h100; BranchIsE = 1; BranchE = 1; PC_EX = 32'h100; BranchTarget = 32'h80;
    rst_n = 1'b0;
    #1;
    check("arst_pv", {31'b0, predicted_valid_IF}, 0);
    check("arst_pc", predicted_PC_IF, 0);
    check("arst_err", {31'b0, predicted_EX_error}, 0);
    #1 rst_n = 1'b1;
    m_reset();
    idle(32'h100); check("post_pv", {31'b0, obs_pv}, 0); check("post_pc", obs_ppc, 0);
    idle(32'h504); check("post_pv2", {31'b0, obs_pv}, 0);
    // random traffic
    for (int k = 0; k < 400; k++)
      step(pool[$urandom_range(0, 5)], $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, pool[$urandom_range(0, 5)],
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
           ($urandom_range(0, 4) == 0) ? ($urandom() & 32'hFFFF_FFFC) : tpool[$urandom_range(0, 3)]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 SHALL have parameter ENTRIES, default 64, meaning the number of direct-mapped entries; it SHALL be a power of two, at least 4.
REQ-002 SHALL have derived parameter IDX_W = log2(ENTRIES); index = PC[IDX_W+1:2]; tag = PC[31:IDX_W+2].
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 PCF  in  32  IF-stage PC used for lookup.
REQ-006 StallD, FlushD  in  1 each  IF/ID register hold / clear.
REQ-007 StallE, FlushE  in  1 each  ID/EX register hold / clear.
REQ-008 PC_EX  in  32  PC of the instruction in EX.
REQ-009 BranchIsE  in  1  EX instruction is a conditional branch.
REQ-010 BranchE  in  1  EX branch resolved taken.
REQ-011 BranchTarget  in  32  EX resolved branch target.
REQ-012 predicted_valid_IF  out  1  predict taken for PCF.
REQ-013 predicted_PC_IF  out  32  predicted target for PCF.
REQ-014 predicted_EX_error  out  1  EX prediction wrong; the next-PC logic redirects.

Function
REQ-015 Each entry SHALL hold: valid (1), tag (32-IDX_W-2), target (32), and a 2-bit saturating counter (ctr).
REQ-016 Lookup SHALL be combinational from registered state: hit = valid[idx] && tag[idx]==PCF tag.
REQ-017 The IF outputs SHALL be: predicted_valid_IF = hit && ctr[1]; predicted_PC_IF = target[idx] when hit, else 0.
REQ-018 Prediction SHALL be carried IF->ID->EX as {taken, target}.
- IF/ID: FlushD clears it to 0; else StallD holds it; else it loads.
- ID/EX: FlushE clears it to 0; else StallE holds it; else it loads.
- Flush SHALL have priority over stall.
REQ-019 predicted_EX_error SHALL be combinational and SHALL be 0 when BranchIsE=0; otherwise it is 1 when either condition holds:
- pred_taken_E != BranchE;
- pred_taken_E && BranchE && pred_target_E != BranchTarget.
REQ-020 Table update SHALL occur only when BranchIsE && !StallE, at most once per EX instruction, indexed and tagged by PC_EX.
REQ-021 On an update hit, ctr SHALL saturate:
- taken: ctr = min(ctr+1, 3) and target = BranchTarget;
- not taken: ctr = max(ctr-1, 0); entry stays valid.
REQ-022 On an update miss with BranchE=1, the entry SHALL be allocated or replaced: valid=1, tag, target=BranchTarget, ctr=2.
REQ-023 On an update miss with BranchE=0, there SHALL be no table change.
REQ-024 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return pre-update contents; the new value is visible the next cycle.
REQ-025 Predictions SHALL never be made for non-branch PCs; only branch PCs are allocated and the tag is full-width.
REQ-026 Resetting the block mid-run SHALL discard all predictions; the only effect is lost accuracy, never an error flag without BranchIsE.

Reset
REQ-027 When rst_n=0, asynchronously: all valid=0, all ctr=0, the IF/ID and ID/EX prediction registers = 0.
REQ-028 The tag and target arrays SHALL NOT require reset.
REQ-029 During and immediately after reset: predicted_valid_IF=0, predicted_PC_IF=0, predicted_EX_error=0.
REQ-030 Deassertion of rst_n SHALL take effect synchronously; the first update SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-031 Cold miss.
- Stimulus: after reset, PCF=0x100; branch at 0x100 in EX with BranchE=1, BranchTarget=0x80.
- Response: predicted_EX_error=1; next PCF=0x100 gives predicted_valid_IF=1 and predicted_PC_IF=0x80.
REQ-032 Counter hysteresis.
- Stimulus: the same branch resolves T,T,N,N,N.
- Response: ctr goes 2->3->3->2->1->0; predicted_valid_IF=1 through the first N, then 0.
REQ-033 Target change.
- Stimulus: entry at 0x100 with ctr=3, target 0x80; EX resolves taken to 0x200.
- Response: predicted_EX_error=1; the next lookup returns 0x200.
REQ-034 Alias and flush.
- Stimulus: taken branch 0x100 is allocated; PCF=0x100+4*ENTRIES is looked up.
- Response: predicted_valid_IF=0.
- Stimulus: FlushE asserted with a predicted-taken instruction entering EX.
- Response: pred_taken_E=0 and no update.
REQ-035 Stall and same-cycle.
- Stimulus: StallE=1 for 3 cycles with BranchIsE=1.
- Response: exactly one update, after the stall releases.
- Stimulus: a same-index lookup and update in one cycle.
- Response: the lookup returns old data.
REQ-036 Async reset mid-run.
- Stimulus: rst_n pulsed low between clock edges with the table populated.
- Response: outputs 0 immediately; all lookups miss afterwards.
